// File: rtl/imem_boot_pkg.sv
// rtl/imem_boot_pkg.sv - shared states, constants and helpers for the instruction-memory boot loader
package imem_boot_pkg;

  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERROR} state_e;

  localparam int BYTES_PER_WORD = 4;
  // Also sizes the instruction memory itself, so both sides agree on the word count.
  localparam int DEFAULT_DEPTH = 32;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// rtl/imem_byte_packer.sv - assembles little-endian 32-bit words from an accepted byte stream
module imem_byte_packer
  import imem_boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] acc_q, acc_d;

  always_comb begin
    lane_d = lane_q;
    acc_d  = acc_q;
    if (flush) begin
      lane_d = '0;
      acc_d  = '0;
    end else if (in_valid) begin
      lane_d = lane_q + 2'd1;
      case (lane_q)
        2'd0:    acc_d[7:0]   = in_data;
        2'd1:    acc_d[15:8]  = in_data;
        2'd2:    acc_d[23:16] = in_data;
        default: acc_d        = acc_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q <= '0;
      acc_q  <= '0;
    end else begin
      lane_q <= lane_d;
      acc_q  <= acc_d;
    end
  end

  // The top byte never lands in the register: the word is complete on the handshake itself.
  assign word_valid = in_valid && (lane_q == 2'(BYTES_PER_WORD - 1));
  assign word_data  = {in_data, acc_q};

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - loads a byte-streamed program into instruction memory and holds the core until done
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LEN_W   = 6,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_start,
  input  logic [LEN_W-1:0]          load_len,
  input  logic                      byte_valid,
  input  logic [7:0]                byte_data,
  output logic                      byte_ready,
  output logic                      imem_we,
  output logic [clog2(DEPTH)-1:0]   imem_waddr,
  output logic [31:0]               imem_wdata,
  output logic                      cpu_hold,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  localparam int AW = clog2(DEPTH);
  localparam int TW = clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] wcnt_q, wcnt_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [AW-1:0]    imem_waddr_q, imem_waddr_d;
  logic [31:0]      imem_wdata_q, imem_wdata_d;
  logic             byte_ready_q, imem_we_q, cpu_hold_q, busy_q, done_q, error_q;

  logic        accept, timeout_hit, flush;
  logic        word_valid;
  logic [31:0] word_data;

  assign accept      = byte_valid && byte_ready_q;
  assign timeout_hit = (state_q == RECV) && !accept && (tcnt_q == TW'(TIMEOUT - 1));
  assign flush       = (state_q != RECV) || timeout_hit;

  imem_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (accept),
    .in_data    (byte_data),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    wcnt_d       = wcnt_q;
    tcnt_d       = tcnt_q;
    imem_waddr_d = imem_waddr_q;
    imem_wdata_d = imem_wdata_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (load_start) begin
          len_d  = load_len;
          wcnt_d = '0;
          tcnt_d = '0;
          if (load_len == '0)                      state_d = DONE;
          else if (32'(load_len) > 32'(DEPTH))     state_d = ERROR;
          else                                     state_d = RECV;
        end
      end
      RECV: begin
        if (word_valid) begin
          state_d      = WRITE;
          tcnt_d       = '0;
          imem_waddr_d = wcnt_q[AW-1:0];
          imem_wdata_d = word_data;
        end else if (accept) begin
          tcnt_d = '0;
        end else if (timeout_hit) begin
          state_d = ERROR;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      WRITE: begin
        wcnt_d  = wcnt_q + LEN_W'(1);
        tcnt_d  = '0;
        state_d = ((wcnt_q + LEN_W'(1)) == len_q) ? DONE : RECV;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status flops follow the next state so every output is a clean register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      wcnt_q       <= '0;
      tcnt_q       <= '0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      cpu_hold_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      wcnt_q       <= wcnt_d;
      tcnt_q       <= tcnt_d;
      imem_waddr_q <= imem_waddr_d;
      imem_wdata_q <= imem_wdata_d;
      byte_ready_q <= (state_d == RECV);
      imem_we_q    <= (state_d == WRITE);
      cpu_hold_q   <= (state_d != DONE);
      busy_q       <= (state_d == RECV) || (state_d == WRITE);
      done_q       <= (state_d == DONE);
      error_q      <= (state_d == ERROR);
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_waddr = imem_waddr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - self-checking bench for imem_boot_loader
module tb_imem_boot_loader;
  import imem_boot_pkg::*;

  localparam int DEPTH   = 32;
  localparam int LEN_W   = 6;
  localparam int TIMEOUT = 1024;
  localparam int AW      = clog2(DEPTH);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             load_start = 1'b0;
  logic [LEN_W-1:0] load_len = '0;
  logic             byte_valid = 1'b0;
  logic [7:0]       byte_data = '0;
  logic             byte_ready, imem_we, cpu_hold, busy, done, error;
  logic [AW-1:0]    imem_waddr;
  logic [31:0]      imem_wdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;
  wr_t        wr_q[$];
  logic [7:0] tx_q[$];

  typedef struct {
    int len;
    int nbytes;
    bit exp_done;
    bit exp_error;
    int exp_writes;
  } vec_t;
  vec_t tbl[6];

  imem_boot_loader #(.DEPTH(DEPTH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_len   (load_len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t w;
    if (imem_we === 1'b1) begin
      w.addr = int'(imem_waddr);
      w.data = imem_wdata;
      w.cyc  = cyc;
      wr_q.push_back(w);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_load(input int len);
    load_len   = LEN_W'(len);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok         = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 3000; i++) begin
      if (byte_ready === 1'b1) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_all(input int n, input int maxgap, output bit ok);
    bit k;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (maxgap > 0) tick(int'($urandom_range(0, maxgap)));
      send_byte(tx_q[i], k);
      ok = ok & k;
    end
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done === 1'b1 || error === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] model_word(input int j);
    return {tx_q[4*j+3], tx_q[4*j+2], tx_q[4*j+1], tx_q[4*j]};
  endfunction

  task automatic check_writes(input string tag, input int n);
    check($sformatf("%s write count", tag), 64'(wr_q.size()), 64'(n));
    for (int j = 0; j < n && j < wr_q.size(); j++) begin
      check($sformatf("%s addr[%0d]", tag, j), 64'(wr_q[j].addr), 64'(j));
      check($sformatf("%s data[%0d]", tag, j), 64'(wr_q[j].data), 64'(model_word(j)));
    end
  endtask

  task automatic run_load(input string tag, input int len, input int nbytes, input int maxgap,
                          input bit exp_done, input bit exp_error, input int exp_writes);
    bit ok;
    wr_q.delete();
    tx_q.delete();
    for (int i = 0; i < nbytes; i++) tx_q.push_back(8'($urandom));
    start_load(len);
    send_all(nbytes, maxgap, ok);
    if (nbytes > 0) check($sformatf("%s bytes accepted", tag), 64'(ok), 64'(1));
    wait_end(ok);
    check($sformatf("%s finished", tag), 64'(ok), 64'(1));
    tick(1);
    check($sformatf("%s done", tag), 64'(done), 64'(exp_done));
    check($sformatf("%s error", tag), 64'(error), 64'(exp_error));
    check($sformatf("%s cpu_hold", tag), 64'(cpu_hold), 64'(!exp_done));
    check($sformatf("%s byte_ready", tag), 64'(byte_ready), 64'(0));
    check_writes(tag, exp_writes);
  endtask

  initial begin
    bit ok, k;
    int c4, c8, c_last, len;
    int gap[8];

    tbl[0] = '{0,   0,   1'b1, 1'b0, 0};
    tbl[1] = '{33,  0,   1'b0, 1'b1, 0};
    tbl[2] = '{63,  0,   1'b0, 1'b1, 0};
    tbl[3] = '{1,   4,   1'b1, 1'b0, 1};
    tbl[4] = '{32,  128, 1'b1, 1'b0, 32};
    tbl[5] = '{3,   12,  1'b1, 1'b0, 3};

    // Reset values, then a long idle stretch with no activity.
    tick(3);
    check("rst cpu_hold", 64'(cpu_hold), 64'(1));
    check("rst done", 64'(done), 64'(0));
    check("rst error", 64'(error), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    check("rst byte_ready", 64'(byte_ready), 64'(0));
    check("rst imem_we", 64'(imem_we), 64'(0));
    check("rst waddr", 64'(imem_waddr), 64'(0));
    check("rst wdata", 64'(imem_wdata), 64'(0));
    reset = 1'b0;
    tick(100);
    check("idle writes", 64'(wr_q.size()), 64'(0));
    check("idle cpu_hold", 64'(cpu_hold), 64'(1));

    // Nominal two-word load with valid held high.
    tx_q = {8'h13, 8'h00, 8'h50, 8'h00, 8'h63, 8'h00, 8'h00, 8'h02};
    start_load(2);
    check("nom busy", 64'(busy), 64'(1));
    ok = 1'b1; c4 = 0; c8 = 0;
    for (int i = 0; i < 8; i++) begin
      send_byte(tx_q[i], k);
      ok = ok & k;
      if (i == 3) c4 = cyc;
      if (i == 7) c8 = cyc;
    end
    check("nom accepted", 64'(ok), 64'(1));
    check("nom we last", 64'(imem_we), 64'(1));
    check("nom done early", 64'(done), 64'(0));
    tick(1);
    check("nom done", 64'(done), 64'(1));
    check("nom cpu_hold", 64'(cpu_hold), 64'(0));
    check("nom word0", 64'(model_word(0)), 64'(32'h00500013));
    check_writes("nom", 2);
    if (wr_q.size() == 2) begin
      check("nom latency w0", 64'(wr_q[0].cyc), 64'(c4));
      check("nom latency w1", 64'(wr_q[1].cyc), 64'(c8));
    end

    // Same load with gaps, a long mid-word stall, and a stray load_start while busy.
    wr_q.delete();
    gap = '{0, 2, 0, 50, 0, 2, 2, 0};
    start_load(2);
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        tick(20);
        load_len   = '0;
        load_start = 1'b1;
        tick(1);
        load_start = 1'b0;
        check("gap start ignored busy", 64'(busy), 64'(1));
        check("gap start ignored ready", 64'(byte_ready), 64'(1));
        tick(29);
      end else begin
        tick(gap[i]);
      end
      send_byte(tx_q[i], k);
      ok = ok & k;
    end
    check("gap accepted", 64'(ok), 64'(1));
    wait_end(ok);
    check("gap finished", 64'(ok), 64'(1));
    tick(1);
    check("gap done", 64'(done), 64'(1));
    check("gap error", 64'(error), 64'(0));
    check_writes("gap", 2);

    // Timeout: two bytes then silence.
    wr_q.delete();
    start_load(1);
    send_byte(8'hAA, k);
    send_byte(8'hBB, k);
    c_last = cyc;
    tick(TIMEOUT - 1);
    check("to cycle", 64'(cyc - c_last), 64'(TIMEOUT - 1));
    check("to error early", 64'(error), 64'(0));
    check("to busy early", 64'(busy), 64'(1));
    tick(1);
    check("to error", 64'(error), 64'(1));
    check("to cpu_hold", 64'(cpu_hold), 64'(1));
    check("to busy", 64'(busy), 64'(0));
    check("to writes", 64'(wr_q.size()), 64'(0));
    start_load(0);
    check("to zero done", 64'(done), 64'(1));
    check("to zero cpu_hold", 64'(cpu_hold), 64'(0));
    check("to zero error", 64'(error), 64'(0));

    // Length overflow straight out of DONE.
    start_load(DEPTH + 1);
    check("ovf error", 64'(error), 64'(1));
    check("ovf cpu_hold", 64'(cpu_hold), 64'(1));
    byte_valid = 1'b1;
    tick(5);
    check("ovf ready", 64'(byte_ready), 64'(0));
    check("ovf writes", 64'(wr_q.size()), 64'(0));
    byte_valid = 1'b0;

    // Asynchronous reset partway through the second word of a four-word load.
    wr_q.delete();
    tx_q = {8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    start_load(4);
    ok = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send_byte(tx_q[i], k);
      ok = ok & k;
    end
    check("mid accepted", 64'(ok), 64'(1));
    check("mid first write", 64'(wr_q.size()), 64'(1));
    byte_valid = 1'b1;
    byte_data  = 8'h18;
    reset      = 1'b1;
    #1;
    check("mid rst cpu_hold", 64'(cpu_hold), 64'(1));
    check("mid rst busy", 64'(busy), 64'(0));
    check("mid rst ready", 64'(byte_ready), 64'(0));
    check("mid rst wdata", 64'(imem_wdata), 64'(0));
    check("mid rst we", 64'(imem_we), 64'(0));
    check("mid rst done", 64'(done), 64'(0));
    tick(5);
    reset      = 1'b0;
    byte_valid = 1'b0;
    tick(3);
    check("mid no more writes", 64'(wr_q.size()), 64'(1));
    run_load("fresh", 1, 4, 0, 1'b1, 1'b0, 1);

    for (int i = 0; i < 6; i++)
      run_load($sformatf("tbl%0d", i), tbl[i].len, tbl[i].nbytes, 1,
               tbl[i].exp_done, tbl[i].exp_error, tbl[i].exp_writes);

    // Random lengths and gaps against the reference rules.
    for (int i = 0; i < 15; i++) begin
      len = int'($urandom_range(0, DEPTH + 4));
      if (len > DEPTH) run_load($sformatf("rnd%0d", i), len, 0, 3, 1'b0, 1'b1, 0);
      else             run_load($sformatf("rnd%0d", i), len, 4 * len, 3, 1'b1, 1'b0, len);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot-time controller for the single-cycle core's word-addressed instruction memory.
- Receives a program as a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Sequences one write per word into instruction memory, starting at word 0.
- Holds the core in stall until a load completes. After that it stays transparent to fetch.

Parameters:
- DEPTH, 32, number of 32-bit instruction words; write address width is clog2(DEPTH).
- LEN_W, 6, width of load_len; must satisfy 2^LEN_W-1 >= DEPTH.
- TIMEOUT, 1024, max idle cycles between bytes inside a load before abort.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- load_start  in  1  one-cycle pulse; begins a load when in IDLE, DONE or ERROR
- load_len  in  LEN_W  number of words to load; sampled on load_start
- byte_valid  in  1  byte stream valid
- byte_data  in  8  byte stream data
- byte_ready  out  1  loader accepts byte this cycle when valid&ready
- imem_we  out  1  instruction memory write strobe, one cycle per word
- imem_waddr  out  clog2(DEPTH)  word address of write
- imem_wdata  out  32  assembled word
- cpu_hold  out  1  stalls PC/fetch of the core while 1
- busy  out  1  load in progress (RECV or WRITE)
- done  out  1  last load completed successfully
- error  out  1  last load aborted (timeout or length overflow)

Behaviour:
- Reset values: state IDLE, byte_ready 0, imem_we 0, imem_waddr 0, imem_wdata 0, cpu_hold 1, busy 0, done 0, error 0, word counter 0, byte lane 0, timeout counter 0.
- States: IDLE, RECV, WRITE, DONE, ERROR. All outputs are registered.
- IDLE:
  - cpu_hold=1.
  - On load_start: latch load_len into len_q and clear done/error.
  - If load_len==0: go to DONE.
  - If load_len>DEPTH: go to ERROR with no writes.
  - Otherwise: go to RECV with word counter 0 and lane 0.
- RECV:
  - byte_ready=1, busy=1.
  - Each accepted byte goes into lane 0..3: bits [7:0] first, [31:24] last (little-endian).
  - Lane increments on each accept. The timeout counter clears on each accept and increments otherwise.
  - After the 4th byte is accepted, go to WRITE. byte_ready is 0 in WRITE, so no byte is lost.
  - If the timeout counter reaches TIMEOUT-1 with no accept: go to ERROR. Any partial word is discarded.
- WRITE:
  - Single cycle: imem_we=1, imem_waddr=word counter, imem_wdata=assembled word.
  - Word counter increments and lane resets to 0.
  - If incremented counter==len_q: go to DONE. Otherwise go back to RECV.
  - Write latency: imem_we is asserted the cycle after the 4th byte handshake.
- DONE:
  - cpu_hold=0, done=1, busy=0.
  - A new load_start re-enters the IDLE decision logic in the same cycle: cpu_hold returns to 1 next cycle and done clears.
- ERROR:
  - cpu_hold=1, error=1. Words already written remain in memory.
  - Leaves only on load_start, using the same decision logic as IDLE.
- load_start during RECV/WRITE is ignored, with no restart and no effect on counters.
- byte_valid while byte_ready=0 is ignored. The source must hold the byte until accepted.
- Asynchronous reset mid-load forces the reset values immediately. Partial memory contents are left as-is, and the core is held.
- The word counter never exceeds DEPTH-1 on a write, guaranteed by the length check.

Decomposition:
- Shared package imem_boot_pkg:
  - state enum {IDLE, RECV, WRITE, DONE, ERROR}
  - localparam BYTES_PER_WORD=4
  - function clog2
  - default DEPTH constant 32, shared with the instruction memory.
- Sub-module imem_byte_packer: lane counter, 4-byte shift/assemble register, word_valid pulse; cleared by a controller flush. The timeout counter and FSM stay in the top level.

Test Plan:
- Reset then idle: reset pulse -> cpu_hold=1, done=0, error=0, imem_we never asserts over 100 cycles.
- Nominal load: load_start with load_len=2, bytes 13,00,50,00,63,00,00,02 with valid held high -> imem_we at word 0 data 0x00500013, then word 1 data 0x02000063, done=1, cpu_hold=0 one cycle after the second write.
- Backpressure/gaps: same 2-word load with byte_valid toggling 1,0,0,1 and a 50-cycle gap mid-word -> identical writes, no error.
- Timeout: load_len=1, send 2 bytes then stop -> error=1 exactly TIMEOUT cycles after last accept, no imem_we, cpu_hold=1; a subsequent load_start with load_len=0 -> done=1, cpu_hold=0.
- Length overflow: load_len=33 with DEPTH=32 -> error=1 next cycle, byte_ready stays 0, no write; load_start pulse while busy in a valid load -> ignored, counters unchanged.
- Reset mid-operation: assert reset after 3 bytes of word 1 in a 4-word load -> outputs return to reset values asynchronously, no further imem_we; a fresh load after release writes from word 0.
